// File: rtl/wb_trace_monitor_pkg.sv
// Shared types and constants for the WB-stage trace monitor.
// The default widths mirror the CPU datapath the monitor is attached to.
package wb_trace_monitor_pkg;

    localparam int unsigned ZERO_REG   = 31;
    localparam int unsigned TRC_DATA_W = 64;
    localparam int unsigned TRC_REG_W  = 5;
    localparam int unsigned TRC_CYC_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED,
        ST_TIMEOUT
    } mon_state_t;

    typedef struct packed {
        logic [TRC_REG_W-1:0]  rd;
        logic [TRC_DATA_W-1:0] data;
        logic [TRC_CYC_W-1:0]  cycle;
    } trace_entry_t;

endpackage

// File: rtl/wb_trace_monitor_fifo.sv
// Synchronous trace FIFO with flush; head entry is presented while not empty.
// A pop on the same cycle frees a slot, so push+pop while full is accepted.
module wb_trace_monitor_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full_o  = (count_q == (AW+1)'(DEPTH));
        empty_o = (count_q == '0);
        do_pop  = pop_i && !empty_o && !flush_i;
        do_push = push_i && !flush_i && (!full_o || do_pop);
        data_o  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/wb_trace_monitor.sv
// Run monitor for the pipelined CPU: traces WB register writes into a FIFO,
// detects halt (PC stuck) and a cycle-budget timeout, and reports final status.
module wb_trace_monitor
    import wb_trace_monitor_pkg::*;
#(
    parameter int unsigned DATA_W      = TRC_DATA_W,
    parameter int unsigned REG_W       = TRC_REG_W,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CYC_W       = TRC_CYC_W,
    parameter int unsigned TIMEOUT     = 1800,
    parameter int unsigned HALT_REPEAT = 4,
    parameter int unsigned FILTER_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic [DATA_W-1:0] pc_if,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              trc_valid,
    input  logic              trc_ready,
    output logic [REG_W-1:0]  trc_rd,
    output logic [DATA_W-1:0] trc_data,
    output logic [CYC_W-1:0]  trc_cycle,
    output logic              running,
    output logic              done,
    output logic              timed_out,
    output logic [CYC_W-1:0]  cycle_cnt,
    output logic [CYC_W-1:0]  wr_count,
    output logic [CYC_W-1:0]  dropped
);

    localparam int unsigned SW = $clog2(HALT_REPEAT);

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic [CYC_W-1:0]  cycle;
    } entry_t;

    mon_state_t        state_q;
    logic [CYC_W-1:0]  cycle_cnt_q;
    logic [CYC_W-1:0]  wr_count_q;
    logic [CYC_W-1:0]  dropped_q;
    logic [SW-1:0]     stuck_q;
    logic [SW-1:0]     stuck_d;
    logic [DATA_W-1:0] pc_prev_q;
    logic              hist_vld_q;

    logic   capture;
    logic   pop;
    logic   drop;
    logic   flush;
    logic   halt;
    logic   tmo;
    logic   fifo_full;
    logic   fifo_empty;
    entry_t wr_entry;
    entry_t head;

    always_comb begin
        capture  = (state_q == ST_RUN) && wb_en &&
                   !((FILTER_ZERO != 0) && (wb_rd == REG_W'(ZERO_REG)));
        pop      = !fifo_empty && trc_ready;
        drop     = capture && fifo_full && !pop;
        flush    = arm && (state_q != ST_RUN);
        wr_entry = '{rd: wb_rd, data: wb_data, cycle: cycle_cnt_q};
        // No history on the first RUN cycle, so it can never count as stuck.
        stuck_d  = (hist_vld_q && (pc_if == pc_prev_q)) ? stuck_q + 1'b1 : '0;
        halt     = (stuck_d == SW'(HALT_REPEAT - 1));
        tmo      = (cycle_cnt_q == CYC_W'(TIMEOUT - 1));
    end

    wb_trace_monitor_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (flush),
        .push_i  (capture),
        .pop_i   (pop),
        .data_i  (wr_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cycle_cnt_q <= '0;
            wr_count_q  <= '0;
            dropped_q   <= '0;
            stuck_q     <= '0;
            pc_prev_q   <= '0;
            hist_vld_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cycle_cnt_q <= (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
                    if (capture && wr_count_q != '1) wr_count_q <= wr_count_q + 1'b1;
                    if (drop && dropped_q != '1)     dropped_q  <= dropped_q + 1'b1;
                    stuck_q    <= stuck_d;
                    pc_prev_q  <= pc_if;
                    hist_vld_q <= 1'b1;
                    if (halt)     state_q <= ST_HALTED;
                    else if (tmo) state_q <= ST_TIMEOUT;
                end
                default: begin
                    if (arm) begin
                        state_q     <= ST_RUN;
                        cycle_cnt_q <= '0;
                        wr_count_q  <= '0;
                        dropped_q   <= '0;
                        stuck_q     <= '0;
                        hist_vld_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        trc_valid = !fifo_empty;
        trc_rd    = trc_valid ? head.rd    : '0;
        trc_data  = trc_valid ? head.data  : '0;
        trc_cycle = trc_valid ? head.cycle : '0;
        running   = (state_q == ST_RUN);
        done      = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);
        timed_out = (state_q == ST_TIMEOUT);
        cycle_cnt = cycle_cnt_q;
        wr_count  = wr_count_q;
        dropped   = dropped_q;
    end

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Scoreboard bench for wb_trace_monitor: a run-level model predicts trace entries
// and status; a separate monitor compares every presented FIFO head.
module tb_wb_trace_monitor;

    localparam int unsigned DATA_W      = 64;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned CYC_W       = 32;
    localparam int unsigned TIMEOUT     = 40;
    localparam int unsigned HALT_REPEAT = 4;
    localparam int unsigned FILTER_ZERO = 1;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;
    localparam int S_TMO  = 3;

    logic              clk;
    logic              rst;
    logic              arm;
    logic [DATA_W-1:0] pc_if;
    logic              wb_en;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              trc_valid;
    logic              trc_ready;
    logic [REG_W-1:0]  trc_rd;
    logic [DATA_W-1:0] trc_data;
    logic [CYC_W-1:0]  trc_cycle;
    logic              running;
    logic              done;
    logic              timed_out;
    logic [CYC_W-1:0]  cycle_cnt;
    logic [CYC_W-1:0]  wr_count;
    logic [CYC_W-1:0]  dropped;

    wb_trace_monitor #(
        .DATA_W      (DATA_W),
        .REG_W       (REG_W),
        .DEPTH       (DEPTH),
        .CYC_W       (CYC_W),
        .TIMEOUT     (TIMEOUT),
        .HALT_REPEAT (HALT_REPEAT),
        .FILTER_ZERO (FILTER_ZERO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .pc_if     (pc_if),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .trc_valid (trc_valid),
        .trc_ready (trc_ready),
        .trc_rd    (trc_rd),
        .trc_data  (trc_data),
        .trc_cycle (trc_cycle),
        .running   (running),
        .done      (done),
        .timed_out (timed_out),
        .cycle_cnt (cycle_cnt),
        .wr_count  (wr_count),
        .dropped   (dropped)
    );

    typedef struct {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic [CYC_W-1:0]  cyc;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] pc_hist[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                m_state;
    longint unsigned   m_cyc;
    longint unsigned   m_wr;
    longint unsigned   m_drop;
    int                m_cnt;
    bit                flush_cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void m_reset();
        m_state = S_IDLE;
        m_cyc   = 0;
        m_wr    = 0;
        m_drop  = 0;
        m_cnt   = 0;
        exp_q.delete();
        pc_hist.delete();
    endfunction

    // Predicts the effect of the coming rising edge from the run-level rules.
    function automatic void m_step(bit a, logic [DATA_W-1:0] pc, bit wen,
                                   logic [REG_W-1:0] rd, logic [DATA_W-1:0] d, bit rdy);
        bit   pop;
        bit   halt;
        bit   tmo;
        exp_t e;
        pop = rdy && (m_cnt > 0);
        if (m_state != S_RUN) begin
            if (a) begin
                m_reset();
                m_state = S_RUN;
            end else if (pop) begin
                m_cnt--;
            end
            return;
        end
        if (wen && !(FILTER_ZERO != 0 && rd == 31)) begin
            m_wr++;
            if (m_cnt < int'(DEPTH) || pop) begin
                e.rd   = rd;
                e.data = d;
                e.cyc  = CYC_W'(m_cyc);
                exp_q.push_back(e);
                m_cnt++;
            end else begin
                m_drop++;
            end
        end
        if (pop) m_cnt--;
        pc_hist.push_back(pc);
        halt = (pc_hist.size() >= int'(HALT_REPEAT));
        if (halt) begin
            for (int k = 1; k < int'(HALT_REPEAT); k++)
                if (pc_hist[pc_hist.size() - 1 - k] != pc) halt = 0;
        end
        tmo = (m_cyc == longint'(TIMEOUT - 1));
        m_cyc++;
        if (halt)     m_state = S_HALT;
        else if (tmo) m_state = S_TMO;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic check_status();
        chk("running",   64'(running),   64'(m_state == S_RUN));
        chk("done",      64'(done),      64'(m_state == S_HALT || m_state == S_TMO));
        chk("timed_out", 64'(timed_out), 64'(m_state == S_TMO));
        chk("cycle_cnt", 64'(cycle_cnt), m_cyc);
        chk("wr_count",  64'(wr_count),  m_wr);
        chk("dropped",   64'(dropped),   m_drop);
        chk("trc_valid", 64'(trc_valid), 64'(m_cnt > 0));
    endtask

    task automatic step(bit a, logic [DATA_W-1:0] pc, bit wen,
                        logic [REG_W-1:0] rd, logic [DATA_W-1:0] d, bit rdy);
        check_status();
        arm       = a;
        pc_if     = pc;
        wb_en     = wen;
        wb_rd     = rd;
        wb_data   = d;
        trc_ready = rdy;
        flush_cyc = a && (m_state != S_RUN);
        m_step(a, pc, wen, rd, d, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        arm       = 1'b0;
        wb_en     = 1'b0;
        trc_ready = 1'b0;
        flush_cyc = 1'b0;
        m_reset();
        @(negedge clk);
        chk("rst_trc_valid", 64'(trc_valid), 0);
        chk("rst_trc_rd",    64'(trc_rd),    0);
        chk("rst_trc_data",  64'(trc_data),  0);
        chk("rst_trc_cycle", 64'(trc_cycle), 0);
        chk("rst_running",   64'(running),   0);
        chk("rst_done",      64'(done),      0);
        chk("rst_timed_out", 64'(timed_out), 0);
        chk("rst_cycle_cnt", 64'(cycle_cnt), 0);
        chk("rst_wr_count",  64'(wr_count),  0);
        chk("rst_dropped",   64'(dropped),   0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    // Monitor: every presented head must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst && trc_valid && !flush_cyc) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL trc_unexpected: got (%0d,%0h,%0d) required no entry",
                             trc_rd, trc_data, trc_cycle);
                end else begin
                    if (trc_rd !== exp_q[0].rd || trc_data !== exp_q[0].data ||
                        trc_cycle !== exp_q[0].cyc) begin
                        n_fail++;
                        $display("FAIL trc_entry: got (%0d,%0h,%0d) required (%0d,%0h,%0d)",
                                 trc_rd, trc_data, trc_cycle,
                                 exp_q[0].rd, exp_q[0].data, exp_q[0].cyc);
                    end
                    if (trc_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] pc;
        rst     = 1'b0;
        arm     = 1'b0;
        pc_if   = '0;
        wb_en   = 1'b0;
        wb_rd   = '0;
        wb_data = '0;
        trc_ready = 1'b0;
        flush_cyc = 1'b0;
        m_reset();
        do_reset();

        // Two writes X1=5 at cycle 2 and X2=7 at cycle 3.
        step(1, 64'h1000, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            step(0, 64'h2000 + 64'(8 * i), (i == 2 || i == 3),
                 (i == 2) ? 5'd1 : 5'd2, (i == 2) ? 64'd5 : 64'd7, 1);
        chk("wr_count_two", 64'(wr_count), 2);

        // Reset while three entries are queued.
        do_reset();
        step(1, 64'h3000, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 64'h3000 + 64'(4 * i), 1, 5'(i + 3), rnd_data(), 0);
        chk("queued_three_valid", 64'(trc_valid), 1);
        do_reset();

        // Overflow, push+pop on full, drain, then XZR filter.
        step(1, 64'h4000, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            step(0, 64'h4000 + 64'(4 * i), 1, 5'(i + 1), rnd_data(), 0);
        chk("overflow_dropped", 64'(dropped), 2);
        chk("overflow_wr_count", 64'(wr_count), 6);
        step(0, 64'h4100, 1, 5'd9, rnd_data(), 1);
        chk("full_pushpop_no_drop", 64'(dropped), 2);
        for (int i = 0; i < 6; i++)
            step(0, 64'h4200 + 64'(4 * i), 0, 0, 0, 1);
        step(0, 64'h4300, 1, 5'd31, rnd_data(), 1);
        step(0, 64'h4304, 0, 0, 0, 1);
        chk("xzr_filtered_wr_count", 64'(wr_count), 7);
        chk("xzr_no_entry", 64'(trc_valid), 0);

        // Halt: PC held at 0x40 from cycle 10.
        do_reset();
        step(1, 64'h5000, 0, 0, 0, 1);
        for (int i = 0; i < 14; i++)
            step(0, (i < 10) ? 64'h5000 + 64'(4 * i) : 64'h40, 0, 0, 0, 1);
        chk("halt_done", 64'(done), 1);
        chk("halt_not_timed_out", 64'(timed_out), 0);
        chk("halt_cycle_cnt", 64'(cycle_cnt), 14);
        for (int i = 0; i < 3; i++)
            step(0, 64'h40, 0, 0, 0, 1);
        chk("halt_cycle_frozen", 64'(cycle_cnt), 14);

        // Timeout with a pending entry, then re-arm from TIMEOUT.
        step(1, 64'h6000, 0, 0, 0, 0);
        for (int i = 0; i < int'(TIMEOUT); i++)
            step(0, 64'h6000 + 64'(4 * i), (i == 5), 5'd4, rnd_data(), 0);
        chk("timeout_flag", 64'(timed_out), 1);
        chk("timeout_cycle_cnt", 64'(cycle_cnt), 64'(TIMEOUT));
        chk("timeout_entry_kept", 64'(trc_valid), 1);
        step(1, 64'h7000, 0, 0, 0, 1);
        chk("rearm_running", 64'(running), 1);
        chk("rearm_cycle_cnt", 64'(cycle_cnt), 0);
        chk("rearm_wr_count", 64'(wr_count), 0);
        chk("rearm_fifo_empty", 64'(trc_valid), 0);

        // Randomized traffic.
        do_reset();
        pc = 64'h0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) != 0) pc = 64'($urandom_range(7) * 4);
            step(($urandom_range(19) == 0), pc, $urandom_range(1) == 1,
                 ($urandom_range(3) == 0) ? 5'd31 : 5'($urandom_range(31)),
                 rnd_data(), $urandom_range(1) == 1);
        end
        for (int i = 0; i < 8; i++)
            step(0, 64'h8000 + 64'(4 * i), 0, 0, 0, 1);
        chk("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
